// File: rtl/sample_writer.sv
// rtl/sample_writer.sv - PRBS x / delayed-attenuated y sample RAM filler (optional noise: SAMPLE_WRITER_NOISE_EN)
module sample_writer #(
  parameter int          ADDR_W    = 13,
  parameter int          DATA_W    = 8,
  parameter int          AMP       = 64,
  parameter logic [15:0] SEED      = 16'hACE1,
`ifdef SAMPLE_WRITER_NOISE_EN
  parameter int          ATTEN_SH  = 1,
  parameter int          NOISE_AMP = 8
`else
  parameter int          ATTEN_SH  = 1
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     start,
  input  logic [ADDR_W-2:0]        delay,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [DATA_W-1:0] wr_data,
  output logic                     busy,
  output logic                     done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL_X = 3'd1;
  localparam logic [2:0] S_PAD    = 3'd2;
  localparam logic [2:0] S_FILL_Y = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED_X = (SEED == 16'h0000) ? 16'h0001 : SEED;

  localparam logic [ADDR_W-1:0] LAST_X = {1'b0, {(ADDR_W-1){1'b1}}};
  localparam logic [ADDR_W-1:0] ONE_A  = 1;
  localparam logic [ADDR_W-2:0] ONE_D  = 1;
  localparam logic signed [DATA_W-1:0] S_POS = DATA_W'(AMP);
  localparam logic signed [DATA_W-1:0] S_NEG = DATA_W'(-AMP);
  localparam logic signed [DATA_W-1:0] S_FIRST = SEED_X[0] ? S_POS : S_NEG;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  logic [2:0]              state;
  logic [ADDR_W-1:0]       addr;     // address of the next write
  logic [15:0]             lfsr;
  logic [ADDR_W-2:0]       dly;
  logic [ADDR_W-2:0]       dly_m1;
  logic signed [DATA_W-1:0] x_sample;
  logic signed [DATA_W-1:0] y_shift;
  logic signed [DATA_W-1:0] y_sample;
  logic signed [DATA_W-1:0] pad_sample;

  assign dly_m1   = dly - ONE_D;
  assign x_sample = lfsr[0] ? S_POS : S_NEG;
  assign y_shift  = x_sample >>> ATTEN_SH;

`ifdef SAMPLE_WRITER_NOISE_EN
  localparam logic [15:0] NSEED_R = ~SEED_X;
  localparam logic [15:0] NSEED   = (NSEED_R == 16'h0000) ? 16'h0001 : NSEED_R;
  localparam logic signed [DATA_W:0] NZ     = (DATA_W+1)'(NOISE_AMP);
  localparam logic signed [DATA_W:0] SAT_HI = (DATA_W+1)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [DATA_W:0] SAT_LO = (DATA_W+1)'(-(1 << (DATA_W-1)));

  logic [15:0] nlfsr;
  logic        will_write;

  function automatic logic signed [DATA_W-1:0] add_noise(input logic signed [DATA_W-1:0] v,
                                                         input logic sgn);
    logic signed [DATA_W:0] sum;
    sum = $signed({v[DATA_W-1], v}) + (sgn ? NZ : -NZ);
    if (sum > SAT_HI) return SAT_HI[DATA_W-1:0];
    if (sum < SAT_LO) return SAT_LO[DATA_W-1:0];
    return sum[DATA_W-1:0];
  endfunction

  assign will_write = ena && (((state == S_IDLE) || (state == S_DONE)) ? start : 1'b1);
  assign y_sample   = add_noise(y_shift, nlfsr[0]);
  assign pad_sample = add_noise('0, nlfsr[0]);

  // Noise LFSR restarts with each fill and steps once per write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      nlfsr <= NSEED;
    end else if (will_write) begin
      if ((state == S_IDLE) || (state == S_DONE)) nlfsr <= lfsr_step(NSEED);
      else                                         nlfsr <= lfsr_step(nlfsr);
    end
  end
`else
  assign y_sample   = y_shift;
  assign pad_sample = '0;
`endif

  // Fill sequencer; the accepted start itself issues the write of x[0].
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      addr    <= '0;
      lfsr    <= SEED_X;
      dly     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (!ena) begin
      wr_en <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_FILL_X: begin
          wr_en   <= 1'b1;
          wr_addr <= addr;
          wr_data <= x_sample;
          addr    <= addr + ONE_A;
          if (addr == LAST_X) begin
            lfsr  <= SEED_X;
            state <= (dly == '0) ? S_FILL_Y : S_PAD;
          end else begin
            lfsr  <= lfsr_step(lfsr);
          end
        end
        S_PAD: begin
          wr_en   <= 1'b1;
          wr_addr <= addr;
          wr_data <= pad_sample;
          addr    <= addr + ONE_A;
          if (addr[ADDR_W-2:0] == dly_m1) state <= S_FILL_Y;
        end
        S_FILL_Y: begin
          wr_en   <= 1'b1;
          wr_addr <= addr;
          wr_data <= y_sample;
          lfsr    <= lfsr_step(lfsr);
          if (&addr) begin
            addr  <= '0;
            state <= S_DONE;
          end else begin
            addr  <= addr + ONE_A;
          end
        end
        default: begin
          // Idle or finished: done flags the fill one cycle after its last write.
          if (state == S_DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
          if (start) begin
            dly     <= delay;
            wr_en   <= 1'b1;
            wr_addr <= '0;
            wr_data <= S_FIRST;
            lfsr    <= lfsr_step(SEED_X);
            addr    <= ONE_A;
            busy    <= 1'b1;
            done    <= 1'b0;
            state   <= S_FILL_X;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/sample_writer.md
Name: sample_writer

Overview:
- Test-signal writer for the correlator's sample memory. It is the write-side counterpart of the ROM read path: it fills a DEPTH-entry signed-sample RAM.
- Lower half holds reference channel x[n], a ±AMP pseudo-random (PRBS) sequence.
- Upper half holds y[n] = x[n−D]·2^−ATTEN_SH, where D is a run-time delay latched at start.
- Sits between the button/switch front end and the sample RAM, so the correlator can be exercised with a known delay.

Parameters:
ADDR_W, 13, memory address width; DEPTH = 2^ADDR_W, HALF = DEPTH/2
DATA_W, 8, signed sample width
AMP, 64, sample magnitude for PRBS bit (must be < 2^(DATA_W−1))
SEED, 16'hACE1, LFSR seed; 0 replaced by 16'h0001
ATTEN_SH, 1, arithmetic right shift applied to y samples
NOISE_AMP, 8, noise magnitude (used only with NOISE_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
ena  in  1  advance enable; 0 freezes all state and deasserts wr_en
start  in  1  one-cycle request to begin a fill
delay  in  ADDR_W-1  delay D in samples, latched on accepted start
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  RAM write address
wr_data  out  DATA_W  signed sample to write
busy  out  1  fill in progress
done  out  1  high after a complete fill until next accepted start or reset

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0; LFSR=SEED; delay register=0. Reset mid-fill aborts the fill; memory contents are undefined.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shift right, new MSB = b0^b2^b3^b5. Output bit b = LFSR[0]. Sample s = b ? +AMP : −AMP. LFSR advances once per PRBS sample written.
- States and transitions:
  - IDLE/DONE: start=1 with ena=1 → latch delay, LFSR←SEED, addr←0, done←0, busy←1, go to FILL_X. start is ignored in every other state.
  - FILL_X: each ena cycle writes x[n]=s at addr n, for n=0..HALF−1. After the write at HALF−1, LFSR←SEED. If D=0 go to FILL_Y, else go to PAD.
  - PAD: writes 0 at addr HALF+n for n=0..D−1, LFSR held. After the last pad write, go to FILL_Y.
  - FILL_Y: writes s>>>ATTEN_SH at HALF+n for n=D..HALF−1, advancing the LFSR. After the write at DEPTH−1, go to DONE: busy←0, done←1.
- Registered outputs:
  - wr_en/wr_addr/wr_data are valid in the cycle after the state decision.
  - First write (addr 0) appears exactly one cycle after the accepted start.
  - Total DEPTH writes with ena held high; last write is at cycle DEPTH after start, done rises the cycle after.
- Write rules: exactly one write per ena=1 cycle. ena=0 → wr_en=0 that cycle, address and LFSR frozen, no sample skipped or duplicated.
- Boundaries:
  - D=0: no PAD, so y[n]=x[n]>>>ATTEN_SH.
  - D=HALF−1 (max): only y[DEPTH−1]=x[0]>>>ATTEN_SH is non-zero.
  - The delay input changing mid-fill has no effect.
  - start and rst=0 in the same cycle: reset wins.
  - Address never wraps; the FSM stops at DEPTH−1.

Optional Feature:
- Macro SAMPLE_WRITER_NOISE_EN.
  - Defined: a second 16-bit LFSR (same taps, seed ~SEED) advances on every write. y samples (FILL_Y and PAD) get ±NOISE_AMP added, sign taken from its bit 0, after the shift. The result saturates to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. x samples are unaffected.
  - Undefined: no second LFSR; y samples are exact as above.

Test Plan:
- Reset then start, D=0, ena=1 → wr_en first high the cycle after start. addr0=0x40 (SEED LSB=1 → +64). addr 4096 = 0x20. DEPTH=8192 writes; done high at cycle 8193.
- Start with D=100 → addr 4096..4195 all 0x00; addr 4196+k equals (x[k])>>>1 for k=0..3995. Checked against a golden LFSR model.
- ena toggled 1/0 every cycle during fill → still exactly 8192 writes, addresses strictly consecutive, data identical to the ena=1 run; done after 16384±1 cycles.
- start pulsed at write 2000, and delay changed mid-fill → ignored: no restart, output identical to an undisturbed run with the original D.
- rst=0 asserted at write 5000 → next cycle wr_en=0, busy=0, done=0. A new start then gives first write addr 0 = 0x40.
- D=4095 → addr 4096..8190 = 0x00, addr 8191 = 0x20. With SAMPLE_WRITER_NOISE_EN: every y value is within ±8 of the noiseless value and within [−128,127].
